// File: rtl/compare_search_if.sv
`default_nettype none
// ============================================================================
//  Module      : compare_search_if
//  Description : Handshake and comparator-facing signal bundle for the
//                compare_search binary-search engine.
//                  start  - request a new search
//                  guess  - candidate value presented to comparator in1
//                  g/e/l  - comparator flags (guess >, ==, < target)
//                  busy   - search in progress
//                  done   - one-cycle completion pulse
//                  found  - located value (valid with done when err=0)
//                  err    - flag sequence was inconsistent
//                  probes - number of evaluated probes in the last search
//                Modport slave is taken by the engine; master by whoever
//                drives start and supplies the comparator flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface compare_search_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] guess;
    logic             g;
    logic             e;
    logic             l;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] found;
    logic             err;
    logic [WIDTH-1:0] probes;

    modport slave (
        input  start,
        input  g,
        input  e,
        input  l,
        output guess,
        output busy,
        output done,
        output found,
        output err,
        output probes
    );

    modport master (
        output start,
        output g,
        output e,
        output l,
        input  guess,
        input  busy,
        input  done,
        input  found,
        input  err,
        input  probes
    );
endinterface
`default_nettype wire

// File: rtl/compare_search.sv
`default_nettype none
// ============================================================================
//  Module      : compare_search
//  Description : Sequential binary-search engine driving a magnitude
//                comparator. Presents candidates on guess (comparator in1),
//                reads back g/e/l, and narrows [lo,hi] until the hidden
//                comparator in2 value is located or the flags prove
//                inconsistent.
//  Ports       : clk   - clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - compare_search_if.slave (start, guess, g, e, l,
//                        busy, done, found, err, probes)
//  Options     : COMPARE_SEARCH_ONEHOT_CHECK_EN - when defined, any EVAL
//                flag pattern other than exactly one of g/e/l set ends the
//                search with err=1. When undefined, flags are decoded with
//                priority e, g, l and an all-zero pattern is taken as l.
//  Revision    : 1.0 - initial release
// ============================================================================
module compare_search #(
    parameter int WIDTH = 4
) (
    input  wire              clk,
    input  wire              rst_n,
    compare_search_if.slave  bus
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROBE = 2'd1,
        S_EVAL  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] C_MAX  = {WIDTH{1'b1}};

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t           r_state;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_guess;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_found;
    logic             r_err;
    logic [WIDTH-1:0] r_probes;

    // ------------------------------------------------------------------------
    // Midpoint of [a,b]; the sum is formed one bit wider so that a+b never
    // overflows, and dropping bit 0 performs the halving.
    // ------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] f_mid(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[WIDTH:1];
    endfunction

    // ------------------------------------------------------------------------
    // Flag decode
    // ------------------------------------------------------------------------
    logic [2:0] w_flags;
    logic       w_take_e;
    logic       w_take_g;
    logic       w_take_l;
    logic       w_bad_flags;

    assign w_flags = {bus.g, bus.e, bus.l};

`ifdef COMPARE_SEARCH_ONEHOT_CHECK_EN
    // Exactly one flag must be set; anything else aborts the search.
    assign w_bad_flags = !((w_flags == 3'b100) || (w_flags == 3'b010) ||
                           (w_flags == 3'b001));
    assign w_take_e    = !w_bad_flags && bus.e;
    assign w_take_g    = !w_bad_flags && bus.g;
    assign w_take_l    = !w_bad_flags && bus.l;
`else
    // Priority decode: e wins over g, g over l; no flag at all behaves as l.
    assign w_bad_flags = 1'b0;
    assign w_take_e    = bus.e;
    assign w_take_g    = !bus.e && bus.g;
    assign w_take_l    = !bus.e && !bus.g;
`endif

    // Candidate neighbours; only used when the empty-range checks have
    // already ruled out guess==lo (for minus) or guess==hi (for plus), so
    // neither can wrap in the path where it is consumed.
    logic [WIDTH-1:0] w_guess_m1;
    logic [WIDTH-1:0] w_guess_p1;

    assign w_guess_m1 = r_guess - C_ONE;
    assign w_guess_p1 = r_guess + C_ONE;

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_lo     <= C_ZERO;
            r_hi     <= C_ZERO;
            r_guess  <= C_ZERO;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_found  <= C_ZERO;
            r_err    <= 1'b0;
            r_probes <= C_ZERO;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_lo     <= C_ZERO;
                        r_hi     <= C_MAX;
                        r_guess  <= f_mid(C_ZERO, C_MAX);
                        r_found  <= C_ZERO;
                        r_err    <= 1'b0;
                        r_probes <= C_ZERO;
                        r_busy   <= 1'b1;
                        r_state  <= S_PROBE;
                    end
                end

                // Gives the comparator one full cycle to settle on the new
                // guess before its flags are looked at.
                S_PROBE: begin
                    r_state <= S_EVAL;
                end

                S_EVAL: begin
                    r_probes <= r_probes + C_ONE;
                    if (w_bad_flags) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_take_e) begin
                        r_found <= r_guess;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_take_g) begin
                        // Target lies below guess; nothing left if guess==lo.
                        if (r_guess == r_lo) begin
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_hi    <= w_guess_m1;
                            r_guess <= f_mid(r_lo, w_guess_m1);
                            r_state <= S_PROBE;
                        end
                    end else if (w_take_l) begin
                        // Target lies above guess; nothing left if guess==hi.
                        if (r_guess == r_hi) begin
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_lo    <= w_guess_p1;
                            r_guess <= f_mid(w_guess_p1, r_hi);
                            r_state <= S_PROBE;
                        end
                    end else begin
                        // Unreachable with the decodes above; fail safe.
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.guess  = r_guess;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.found  = r_found;
    assign bus.err    = r_err;
    assign bus.probes = r_probes;

endmodule
`default_nettype wire

// File: doc/compare_search.md
# compare_search

Sequential binary-search engine that sits on the driving side of the 4-bit magnitude comparator. It presents candidate values to the comparator's `in1` port and reads back its `g`/`e`/`l` flags. From these it locates the unknown value held on the comparator's `in2` port, then reports the value found, how many probes it took, and whether the flag sequence was inconsistent.

## Interface
- `WIDTH`, default 4: width of the candidate, the result, and the comparator operands.
- `clk  input  1`: single clock; all state updates on rising edge.
- `rst_n  input  1`: reset, asynchronous and active-low.
- `start  input  1`: begin a search; sampled only in IDLE.
- `guess  output  WIDTH`: registered candidate, wired to comparator `in1`.
- `g  input  1`: comparator flag, guess > target.
- `e  input  1`: comparator flag, guess == target.
- `l  input  1`: comparator flag, guess < target.
- `busy  output  1`: high from the cycle after `start` is accepted until the DONE cycle (exclusive).
- `done  output  1`: one-cycle pulse in the DONE state.
- `found  output  WIDTH`: located value; valid when `done`=1 and `err`=0; held until the next accepted `start`.
- `err  output  1`: search failed; valid with `done`; held until the next accepted `start`.
- `probes  output  WIDTH`: number of EVAL cycles in the last search; held until the next accepted `start`.

## Operation
- States: IDLE, PROBE, EVAL, DONE.
- Internal registers: `lo` and `hi`, each WIDTH bits.
- Candidate: mid(lo,hi) = (lo+hi)>>1, computed at WIDTH+1 bits so there is no overflow, then truncated to WIDTH bits.
- IDLE, `start`=1:
  - `lo`=0, `hi`=2^WIDTH−1, `guess`=mid.
  - `found`, `err`, `probes` cleared.
  - Go to PROBE.
- IDLE, `start`=0: stay in IDLE; all outputs hold.
- PROBE: settle cycle; flags ignored; go to EVAL.
- EVAL: `probes`+=1, then the flags are decoded:
  - e: `found`=`guess`; go to DONE.
  - g: if `guess`==`lo`, set `err`=1 and go to DONE. Otherwise `hi`=`guess`−1, `guess`=mid(lo, guess−1), go to PROBE.
  - l: if `guess`==`hi`, set `err`=1 and go to DONE. Otherwise `lo`=`guess`+1, `guess`=mid(guess+1, hi), go to PROBE.
- The empty-range checks (`guess`==`lo` on g, `guess`==`hi` on l) replace any underflow or wrap of `lo`/`hi`. `lo`/`hi` never wrap.
- DONE: `done`=1 for exactly one cycle, then go to IDLE. `start` is ignored in DONE.
- `start` is ignored while `busy`=1.
- A consistent comparator terminates within WIDTH+1 probes.
- `guess` holds its last value in IDLE and DONE.

## Timing
- Reset values: state IDLE, `guess`=0, `busy`=0, `done`=0, `found`=0, `err`=0, `probes`=0, `lo`=0, `hi`=0.
- Reset mid-search: all registers return to their reset values immediately, independent of `clk`. After reset deassertion, only a new `start` begins a search.
- Numbering: clock edge 0 accepts `start`; cycle n is the cycle following edge n−1.
- Probe k (k=1..N) drives `guess` in cycle 2k−1 and samples the flags in cycle 2k.
- `done` is high in cycle 2N+1. Latency from `start` to `done` is 2N+1 cycles; 3 at minimum, 2·WIDTH+3 at maximum.
- The comparator path must be combinational within one cycle. Flags are sampled only in EVAL, one full cycle after `guess` changes.

## Configuration
- `COMPARE_SEARCH_ONEHOT_CHECK_EN` defined:
  - In EVAL, any flag pattern other than exactly one of g/e/l set gives `err`=1 and a transition to DONE.
  - `probes` counts that EVAL.
- `COMPARE_SEARCH_ONEHOT_CHECK_EN` undefined:
  - No check. Decode priority is e, then g, then l.
  - All-zero flags are treated as l.

## Test plan
- Target 7, WIDTH=4: `guess`=7, `e`=1 at the first EVAL → `done` in cycle 3, `found`=7, `probes`=1, `err`=0.
- Target 15: guess sequence 7,11,13,14,15 → `done` in cycle 11, `found`=15, `probes`=5.
- Target 0: guess sequence 7,3,1,0 → `done` in cycle 9, `found`=0, `probes`=4.
- Faulty comparator forcing `l`=1 always: guesses 7,11,13,14,15; at 15, `guess`==`hi` → `err`=1, `done` in cycle 11, `probes`=5.
- `start` pulsed in cycles 2 and 4 during a target-15 search: ignored, result unchanged. Reset asserted in cycle 5: `busy`/`guess`/`probes` go to 0 at once, and there is no `done` until a new `start`.
- With `COMPARE_SEARCH_ONEHOT_CHECK_EN` defined, `g`=`e`=1 at the first EVAL → `err`=1, `probes`=1. Undefined, the same stimulus gives `found`=7, `err`=0.
